// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared phase/sample formats and quarter-wave table generator
package synth_pkg;

    localparam int PHASE_W  = 20;
    localparam int SAMPLE_W = 16;
    localparam int ROM_AW   = 8;

    typedef logic [1:0] quadrant_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LOOKUP
    } wave_state_t;

    localparam longint PI_Q30 = 64'sd3373259426;

    // round(32767 * sin(pi * (2i+1) / 1024)) via a Q30 Taylor series, evaluated at elaboration
    function automatic logic [SAMPLE_W-1:0] sine_entry(input int idx);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint scaled;
        x    = (PI_Q30 * longint'(2 * idx + 1)) >>> 10;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k <= 7; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        scaled = (acc * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
        return SAMPLE_W'(scaled);
    endfunction

endpackage

// File: rtl/sine_rom.sv
// rtl/sine_rom.sv - 256x16 quarter-wave sine ROM with registered read data
module sine_rom
    import synth_pkg::*;
(
    input  logic                clk,
    input  logic [ROM_AW-1:0]   addr,
    output logic [SAMPLE_W-1:0] data
);

    logic [SAMPLE_W-1:0] rom_table [2**ROM_AW];

    for (genvar i = 0; i < 2**ROM_AW; i++) begin : g_rom
        localparam logic [SAMPLE_W-1:0] ENTRY = sine_entry(i);
        assign rom_table[i] = ENTRY;
    end

    always_ff @(posedge clk) begin
        data <= rom_table[addr];
    end

endmodule

// File: rtl/note_wave_reader.sv
// rtl/note_wave_reader.sv - phase-accumulating quarter-wave sine source for one voice
module note_wave_reader
    import synth_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [PHASE_W-1:0]  step_size,
    input  logic                active,
    input  logic                generate_next_sample,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_ready,
    output logic                overrun
);

    wave_state_t          state;
    logic [PHASE_W-1:0]   phase;
    logic [PHASE_W-1:0]   step_q;
    logic [ROM_AW+1:0]    phase_hi;
    logic                 silent;
    quadrant_t            quad;
    logic [ROM_AW-1:0]    idx;
    logic [ROM_AW-1:0]    rom_addr;
    logic [SAMPLE_W-1:0]  rom_data;

    // Only quadrant and integer index of the latched phase are needed downstream
    assign quad     = phase_hi[ROM_AW+1 -: 2];
    assign idx      = phase_hi[ROM_AW-1:0];
    assign rom_addr = quad[0] ? ~idx : idx;

    sine_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            phase        <= '0;
            step_q       <= '0;
            phase_hi     <= '0;
            silent       <= 1'b0;
            sample       <= '0;
            sample_ready <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_ready <= 1'b0;
            if (generate_next_sample && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!active) begin
                        phase <= '0;
                    end
                    if (generate_next_sample) begin
                        phase_hi <= phase[PHASE_W-1 -: ROM_AW+2];
                        step_q   <= step_size;
                        silent   <= !active;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    phase <= silent ? '0 : phase + step_q;
                    state <= LOOKUP;
                end
                LOOKUP: begin
                    if (silent) begin
                        sample <= '0;
                    end else if (quad[1]) begin
                        sample <= SAMPLE_W'(0) - rom_data;
                    end else begin
                        sample <= rom_data;
                    end
                    sample_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
